// File: rtl/gray_seq_checker.sv
// Purpose: decode a gray-coded count stream and check each valid step is exactly +1 mod 2^WIDTH.
// Latency: 1 cycle from a valid sample to bin_out/bin_vld/locked/step_err/wrap_pulse/err_cnt.
// Backpressure: none; every cycle with gray_vld=1 is consumed, gray_vld=0 holds all state.
module gray_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int SYNC_LEN  = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 gray_vld,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_vld,
  output logic                 locked,
  output logic                 step_err,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // good_cnt only ever holds 0..SYNC_LEN-1; one extra value covers the compare target
  localparam int GW = $clog2(SYNC_LEN + 1);
  localparam logic [GW-1:0] SYNC_TGT = GW'(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCK
  } state_t;

  state_t          state;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_inc;
  logic [WIDTH-1:0] dec;
  logic            step_good;
  logic            step_stall;
  logic            step_wrap;

  // gray to binary: each binary bit is the xor of all gray bits at or above it
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ gray_in[i];
    end
  end

  // bin_out always holds the previous decoded sample, so it doubles as the step reference
  assign step_good  = (dec == bin_out + WIDTH'(1));
  assign step_stall = (dec == bin_out);
  assign step_wrap  = (bin_out == '1) && (dec == '0);
  assign good_inc   = good_cnt + GW'(1);

  // lock FSM, step classification and all registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      good_cnt   <= '0;
      bin_out    <= '0;
      bin_vld    <= 1'b0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_cnt    <= '0;
    end else begin
      bin_vld    <= gray_vld;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      if (gray_vld) begin
        bin_out <= dec;
        case (state)
          IDLE: begin
            // first sample only seeds the reference, nothing to compare against yet
            state    <= SYNC;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
          SYNC: begin
            if (step_good) begin
              if (good_inc == SYNC_TGT) begin
                state    <= LOCK;
                good_cnt <= '0;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_inc;
              end
            end else if (!step_stall) begin
              good_cnt <= '0;
            end
          end
          LOCK: begin
            if (step_good) begin
              wrap_pulse <= step_wrap;
            end else if (!step_stall) begin
              step_err <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
              end
              state    <= SYNC;
              good_cnt <= '0;
              locked   <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
